// File: rtl/ldl_count_v2.sv
// Bounded up/down counter with programmable step and bounds, wrap or saturate
// policy, synchronous clear/load, registered terminal-count pulse and optional one-shot stop.
module ldl_count_v2 #(
  parameter int WIDTH   = 8,
  parameter int STEP_W  = 1,
  parameter int WRAP    = 1,
  parameter int ONESHOT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              dir,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  min,
  input  logic [WIDTH-1:0]  max,
  output logic [WIDTH-1:0]  dout,
  output logic              tc,
  output logic              done
);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   step_x;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             inc_term;
  logic             dec_term;
  logic [WIDTH-1:0] load_clamped;

  // One extra bit keeps the carry (increment) and borrow (decrement) visible.
  assign step_x = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
  assign sum    = {1'b0, dout_q} + step_x;
  assign diff   = {1'b0, dout_q} - step_x;

  assign inc_term = (dout_q >= max) || (sum > {1'b0, max});
  assign dec_term = (dout_q <= min) || diff[WIDTH] || (diff[WIDTH-1:0] < min);

  always_comb begin
    load_clamped = load_val;
    if (load_val < min)
      load_clamped = min;
    else if (load_val > max)
      load_clamped = max;
  end

  always_comb begin
    dout_d = dout_q;
    tc_d   = 1'b0;
    done_d = done_q;
    if (clr) begin
      dout_d = dir ? max : min;
      done_d = 1'b0;
    end else if (load) begin
      dout_d = load_clamped;
      done_d = 1'b0;
    end else if (en && !done_q) begin
      if (!dir) begin
        if (inc_term) begin
          dout_d = (WRAP != 0) ? min : max;
          tc_d   = 1'b1;
          if (ONESHOT != 0) done_d = 1'b1;
        end else begin
          dout_d = sum[WIDTH-1:0];
        end
      end else begin
        if (dec_term) begin
          dout_d = (WRAP != 0) ? max : min;
          tc_d   = 1'b1;
          if (ONESHOT != 0) done_d = 1'b1;
        end else begin
          dout_d = diff[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      tc_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      tc_q   <= tc_d;
      done_q <= done_d;
    end
  end

  assign dout = dout_q;
  assign tc   = tc_q;
  assign done = done_q;

  // Inverted bounds make the terminal rules meaningless.
  assert property (@(posedge clk) disable iff (rst) (en | clr | load) |-> (min <= max));

endmodule
